// File: rtl/shift_pkg.sv
// Shared constants and bundle type for the shift decode/issue front-end.
package shift_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]  alu_ctrl;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  rd;
      logic        wr_en;
      logic        illegal;
   } shift_bundle_t;

   localparam int unsigned BUNDLE_W = $bits(shift_bundle_t);

endpackage

// File: rtl/shift_dec_skid.sv
// Output buffering for issued bundles. SHIFT_DEC_SKID_EN selects a two-entry
// skid buffer with registered in_ready; otherwise a single output register.
module shift_dec_skid #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

`ifdef SHIFT_DEC_SKID_EN
   logic [W-1:0] head_q, head_d, skid_q, skid_d;
   logic         head_v_q, head_v_d, skid_v_q, skid_v_d;
   logic         rdy_q, rdy_d;
   logic         push, pop;

   assign push = in_valid && rdy_q;
   assign pop  = head_v_q && out_ready;

   // Pop shifts the skid entry forward; a push fills the first free slot.
   always_comb begin
      head_d   = head_q;
      head_v_d = head_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         head_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else begin
         if (pop) begin
            head_d   = skid_q;
            head_v_d = skid_v_q;
            skid_v_d = 1'b0;
         end
         if (push) begin
            if (!head_v_d) begin
               head_d   = in_data;
               head_v_d = 1'b1;
            end else begin
               skid_d   = in_data;
               skid_v_d = 1'b1;
            end
         end
      end
      rdy_d = !(head_v_d && skid_v_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q   <= '0;
         skid_q   <= '0;
         head_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         head_q   <= head_d;
         skid_q   <= skid_d;
         head_v_q <= head_v_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = head_v_q;
   assign out_data  = head_q;
`else
   logic [W-1:0] data_q;
   logic         valid_q;

   assign in_ready = !valid_q || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) data_q <= in_data;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
`endif

endmodule

// File: rtl/shift_decode_issue.sv
// Decodes RV32I shift instructions into ALU control and issues a registered
// operand bundle. Build option: SHIFT_DEC_SKID_EN (two-entry skid buffer).
module shift_decode_issue
   import shift_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_rs1_data,
   input  logic [31:0]      in_rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_ctrl,
   output logic [31:0]      out_op_a,
   output logic [31:0]      out_op_b,
   output logic [4:0]       out_rd,
   output logic             out_wr_en,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [6:0]    opcode, funct7;
   logic [2:0]    funct3;
   logic          is_r, is_i;
   shift_bundle_t dec, issued;
   logic [CNT_W-1:0] cnt_q;
   logic          count_en;
   logic          unused_rs1_idx;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign is_r   = (opcode == OPC_OP);
   assign is_i   = (opcode == OPC_OP_IMM);

   // Register indices arrive pre-read as operand data.
   assign unused_rs1_idx = ^in_instr[19:15];

   // Shift decode; anything unrecognised leaves a zeroed, illegal bundle.
   always_comb begin
      dec          = '0;
      dec.alu_ctrl = ALU_NOP;
      if (is_r || is_i) begin
         if (funct7 == F7_BASE && funct3 == F3_SLL)     dec.alu_ctrl = ALU_SLL;
         else if (funct7 == F7_BASE && funct3 == F3_SR) dec.alu_ctrl = ALU_SRL;
         else if (funct7 == F7_ALT && funct3 == F3_SR)  dec.alu_ctrl = ALU_SRA;
      end
      dec.illegal = (dec.alu_ctrl == ALU_NOP);
      dec.rd      = in_instr[11:7];
      if (!dec.illegal) begin
         dec.op_a  = in_rs1_data;
         dec.op_b  = is_r ? in_rs2_data : 32'(in_instr[24:20]);
         dec.wr_en = (in_instr[11:7] != 5'd0);
      end
   end

   // Discarded (flushed) inputs are not counted.
   assign count_en = in_valid && in_ready && !flush && dec.illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   cnt_q <= '0;
      else if (count_en && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
   end

   shift_dec_skid #(.W(BUNDLE_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (issued)
   );

   assign out_alu_ctrl = issued.alu_ctrl;
   assign out_op_a     = issued.op_a;
   assign out_op_b     = issued.op_b;
   assign out_rd       = issued.rd;
   assign out_wr_en    = issued.wr_en;
   assign out_illegal  = issued.illegal;
   assign illegal_cnt  = cnt_q;

endmodule

// File: doc/shift_decode_issue.md
# shift_decode_issue

Front-end for the shift datapath. Accepts a 32-bit RV32I instruction and its register-file operands over a valid/ready handshake. Decodes the six shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI) into the 4-bit ALU control code the shift unit consumes. Issues a registered operand bundle downstream over a second valid/ready handshake, and counts illegal encodings.

## Interface
Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  drop all buffered entries
- in_valid  in  1  instruction/operand bundle valid
- in_ready  out  1  block can accept a bundle
- in_instr  in  32  raw instruction word
- in_rs1_data  in  32  register-file value for rs1
- in_rs2_data  in  32  register-file value for rs2
- out_valid  out  1  issued bundle valid
- out_ready  in  1  shift unit accepts bundle
- out_alu_ctrl  out  4  0101 SLL, 0110 SRL, 0111 SRA, 0000 none
- out_op_a  out  32  shift source (rs1 value)
- out_op_b  out  32  shift amount operand; only bits [4:0] are used downstream
- out_rd  out  5  destination register index
- out_wr_en  out  1  writeback enable
- out_illegal  out  1  bundle carries an undecodable instruction
- illegal_cnt  out  CNT_W  saturating count of accepted illegal bundles

## Operation
- R-type (opcode 0110011), funct7 0000000:
  - funct3 001 → SLL
  - funct3 101 → SRL
- R-type, funct7 0100000, funct3 101 → SRA
- I-type (opcode 0010011), instr[31:25]=0000000:
  - funct3 001 → SLLI
  - funct3 101 → SRLI
- I-type, instr[31:25]=0100000, funct3 101 → SRAI
- Operand selection:
  - op_b = in_rs2_data for R-type.
  - op_b = {27'b0, instr[24:20]} for I-type.
  - op_a = in_rs1_data always.
- Writeback: out_rd = instr[11:7]; out_wr_en = legal && rd≠0.
- Any other encoding is illegal:
  - out_alu_ctrl=0000, out_illegal=1, out_wr_en=0, op_a/op_b=0.
  - The bundle is still issued, in order.
- illegal_cnt increments by 1 on each accepted illegal bundle and saturates at all-ones.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Flush:
  - All entries are invalid the following cycle; an input presented in the flush cycle is discarded.
  - illegal_cnt is unaffected by flush and does not count a discarded bundle.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Reset values: out_valid=0, out_* data=0, illegal_cnt=0.
- in_ready reset value: 1 (with macro), or combinational as defined below (without macro).
- Output bundle fields are stable while out_valid && !out_ready.
- Simultaneous input and output transfer at full occupancy sustains 1 bundle/cycle.
- Reset asserted mid-transfer empties all state immediately; the next cycle after release may accept.

## Configuration
- SHIFT_DEC_SKID_EN defined:
  - Two-entry skid buffer.
  - in_ready is a registered value, in_ready = !(2 entries held).
  - No combinational path from out_ready to in_ready.
- SHIFT_DEC_SKID_EN undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational).
- Ordering, latency and decode are identical in both builds.

## Structure
- Shared package shift_pkg holds:
  - ALU control constants ALU_SLL=4'b0101, ALU_SRL=4'b0110, ALU_SRA=4'b0111, ALU_NOP=4'b0000.
  - Opcode, funct3 and funct7 constants.
  - A packed bundle typedef (alu_ctrl, op_a, op_b, rd, wr_en, illegal).
- Decode is combinational logic in the top module.
- Buffering is sub-module shift_dec_skid, parameterised on bundle width.

## Test plan
- 0x00209133 (SLL x2,x1,x2), rs1=0x1, rs2=0x24 → next cycle: alu_ctrl=0101, op_a=0x1, op_b=0x24, rd=2, wr_en=1.
- 0x41F35293 (SRAI x5,x6,31), rs1=0x80000000 → alu_ctrl=0111, op_b=0x1F, rd=5, illegal=0.
- 0x40009093 (SLLI with bit30 set) → alu_ctrl=0000, illegal=1, wr_en=0, illegal_cnt 0→1. A further 300 illegal bundles leave illegal_cnt at 0xFF.
- out_ready held low while 3 back-to-back SLLIs are offered:
  - With macro: 2 accepted, then in_ready=0.
  - Without macro: 1 accepted.
  - Releasing out_ready drains all 3 in issue order with no loss or duplication.
- flush asserted in the same cycle as in_valid with 2 entries held → out_valid=0 next cycle, the offered bundle is never issued, illegal_cnt unchanged.
- rst_n pulsed low while out_valid=1 → out_valid=0 immediately, illegal_cnt=0, normal issue resumes after release.
